// File: rtl/link_master_fsm_if.sv
// Byte-link bundle between the local producer, the link master and the receiving slave.
// The master view drives in_ready/req/data_out. The slave view is the environment's side.
interface link_master_fsm_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ack;
  logic       req;
  logic [7:0] data_out;

  modport master (
    input  in_valid, in_data, ack,
    output in_ready, req, data_out
  );

  modport slave (
    output in_valid, in_data, ack,
    input  in_ready, req, data_out
  );
endinterface

// File: rtl/link_master_fsm.sv
// Transmit side of the byte link. Producer bytes are queued in a small FIFO and sent one at
// a time over a 4-phase req/ack handshake, with a sent counter and a sticky ack-timeout flag.
module link_master_fsm #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  link_master_fsm_if.master bus,
  output logic              busy,
  output logic [7:0]        sent_cnt,
  output logic              timeout_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    M_IDLE      = 2'd0,
    M_REQ       = 2'd1,
    M_WAIT_ACK0 = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr, r_count;
  logic          r_req, w_req_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic [7:0]    r_tmo, w_tmo_nxt;
  logic [7:0]    r_sent, w_sent_nxt;
  logic          r_terr, w_terr_nxt;
  logic          w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == PW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid && !w_full;
  // The head leaves the FIFO only when the slave acknowledges it; a timeout keeps it for retry.
  assign w_pop   = (r_state == M_REQ) && bus.ack;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= M_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_tmo   <= '0;
      r_sent  <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_tmo   <= w_tmo_nxt;
      r_sent  <= w_sent_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_tmo_nxt   = r_tmo;
    w_sent_nxt  = r_sent;
    w_terr_nxt  = r_terr;
    case (r_state)
      M_IDLE: begin
        if (!w_empty) begin
          w_req_nxt   = 1'b1;
          w_data_nxt  = r_mem[r_rptr[AW-1:0]];
          w_tmo_nxt   = '0;
          w_state_nxt = M_REQ;
        end
      end
      M_REQ: begin
        if (bus.ack) begin
          w_req_nxt   = 1'b0;
          w_sent_nxt  = r_sent + 8'd1;
          w_state_nxt = M_WAIT_ACK0;
        end else if (r_tmo == 8'(TIMEOUT - 1)) begin
          w_req_nxt   = 1'b0;
          w_terr_nxt  = 1'b1;
          w_state_nxt = M_WAIT_ACK0;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      M_WAIT_ACK0: begin
        if (!bus.ack) w_state_nxt = M_IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = M_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = !w_full;
  assign bus.req       = r_req;
  assign bus.data_out  = r_data;
  assign busy          = (r_state != M_IDLE) || !w_empty;
  assign sent_cnt      = r_sent;
  assign timeout_err   = r_terr;

endmodule

// File: tb/tb_link_master_fsm.sv
// Directed + randomized bench for link_master_fsm. The bench plays producer and slave and keeps a
// queue of bytes owed to the slave plus a running count of acknowledged bytes.
module tb_link_master_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] sent_cnt;
  logic       timeout_err;

  link_master_fsm_if bus ();

  link_master_fsm #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .sent_cnt    (sent_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int         n_asrt = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         exp_sent = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("req_rise", {31'd0, bus.req}, 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("push_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    exp_q.push_back(b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Slave side: wait for req, hold off ack for 'delay' cycles, capture, then complete the 4-phase.
  task automatic serve(input int delay);
    logic [7:0] cap, expb;
    wait_req();
    cap = bus.data_out;
    repeat (delay) begin
      tick();
      chk("req_hold", {31'd0, bus.req}, 32'd1);
      chk("data_stable", {24'd0, bus.data_out}, {24'd0, cap});
    end
    if (exp_q.size() > 0) expb = exp_q.pop_front();
    else expb = 8'hxx;
    chk("capture_order", {24'd0, cap}, {24'd0, expb});
    bus.ack = 1'b1;
    tick();
    chk("req_drop_on_ack", {31'd0, bus.req}, 32'd0);
    exp_sent++;
    chk("sent_cnt", {24'd0, sent_cnt}, {24'd0, 8'(exp_sent)});
    bus.ack = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, saw, total, nb;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ack      = 1'b0;
    repeat (2) tick();
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_data", {24'd0, bus.data_out}, 32'd0);
    chk("rst_sent", {24'd0, sent_cnt}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // First-word latency and a single transfer
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    bus.in_valid = 1'b0;
    chk("lat_n1_req", {31'd0, bus.req}, 32'd0);
    tick();
    chk("lat_n2_req", {31'd0, bus.req}, 32'd1);
    chk("lat_n2_data", {24'd0, bus.data_out}, 32'hA5);
    serve(1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Fill the FIFO, then drain in order
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    serve($urandom_range(0, 3));
    chk("ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
    push_byte(8'h05);
    repeat (4) serve($urandom_range(0, 3));

    // Ack timeout and retry of the same byte
    push_byte(8'h3C);
    wait_req();
    hi = 1;
    while (bus.req === 1'b1 && hi < 40) begin
      tick();
      if (bus.req === 1'b1) hi++;
    end
    chk("tmo_req_cycles", 32'(hi), 32'd15);
    chk("tmo_flag", {31'd0, timeout_err}, 32'd1);
    chk("tmo_no_count", {24'd0, sent_cnt}, {24'd0, 8'(exp_sent)});
    serve(2);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // Spurious ack while idle and empty
    chk("spur_pre_busy", {31'd0, busy}, 32'd0);
    bus.ack = 1'b1;
    tick();
    tick();
    bus.ack = 1'b0;
    tick();
    chk("spur_busy", {31'd0, busy}, 32'd0);
    chk("spur_req", {31'd0, bus.req}, 32'd0);
    chk("spur_sent", {24'd0, sent_cnt}, {24'd0, 8'(exp_sent)});

    // Reset in the middle of a transfer with bytes queued
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_req();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'd0, bus.req}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mrst_sent", {24'd0, sent_cnt}, 32'd0);
    chk("mrst_terr", {31'd0, timeout_err}, 32'd0);
    exp_q.delete();
    exp_sent = 0;
    tick();
    rst_n = 1'b1;
    saw = 0;
    repeat (20) begin
      tick();
      if (bus.req !== 1'b0) saw = 1;
    end
    chk("mrst_no_req", 32'(saw), 32'd0);

    // 256 random bytes in small bursts; counter must wrap to zero
    total = 0;
    while (total < 256) begin
      nb = $urandom_range(1, 3);
      if (nb > 256 - total) nb = 256 - total;
      for (int k = 0; k < nb; k++) push_byte(8'($urandom));
      for (int k = 0; k < nb; k++) serve($urandom_range(0, 4));
      total += nb;
    end
    chk("wrap_sent", {24'd0, sent_cnt}, 32'd0);
    chk("wrap_busy", {31'd0, busy}, 32'd0);
    chk("wrap_terr", {31'd0, timeout_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
